// File: rtl/harmonic_mag_scheduler.sv
// -----------------------------------------------------------------------------
// harmonic_mag_scheduler
//
// Time-shares one magnitude unit across NUM_HARMONICS complex coefficients of
// a frame. Each coefficient is handed over with a start/done handshake. The
// results are collected into a vector, which is published with a one-cycle
// valid strobe. One overrun frame can be buffered. Further overrun frames are
// dropped and counted. A watchdog frees the unit if it never answers.
//
// Ports
//   clk_in, rst_in     clock, synchronous active-high reset
//   frame_valid_in     one-cycle strobe, frame_coeffs_in valid
//   frame_coeffs_in    packed coefficients, index 0 in the LSBs
//   mag_start_out      one-cycle start to the magnitude unit
//   mag_coeff_out      coefficient for the unit, held from start to done/timeout
//   mag_done_in        one-cycle result strobe from the unit
//   mag_in             result, valid with mag_done_in
//   mag_clear_out      one-cycle clear to the unit when the watchdog fires
//   mags_out           last completed magnitude vector, index 0 in the LSBs
//   mags_valid_out     one-cycle strobe, mags_out updated this cycle
//   busy_out           controller is not idle
//   frame_dropped_out  one-cycle strobe, incoming frame discarded
//   drop_count_out     saturating count of dropped frames
//   timeout_err_out    sticky flag, watchdog has fired
//
// FSM
//   state   | meaning
//   S_IDLE  | no frame in work, waiting for frame_valid_in
//   S_ISSUE | one cycle: start the unit on coefficient idx, arm watchdog
//   S_WAIT  | waiting for done or watchdog expiry for coefficient idx
//   S_DONE  | one cycle: publish vector, then promote pending or go idle
// -----------------------------------------------------------------------------
module harmonic_mag_scheduler #(
  parameter int NUM_HARMONICS = 5,
  parameter int COEFF_W       = 32,
  parameter int MAG_W         = 32,
  parameter int TIMEOUT       = 64
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             frame_valid_in,
  input  logic [NUM_HARMONICS*COEFF_W-1:0] frame_coeffs_in,
  output logic                             mag_start_out,
  output logic [COEFF_W-1:0]               mag_coeff_out,
  input  logic                             mag_done_in,
  input  logic [MAG_W-1:0]                 mag_in,
  output logic                             mag_clear_out,
  output logic [NUM_HARMONICS*MAG_W-1:0]   mags_out,
  output logic                             mags_valid_out,
  output logic                             busy_out,
  output logic                             frame_dropped_out,
  output logic [7:0]                       drop_count_out,
  output logic                             timeout_err_out
);

  localparam int IDX_W = (NUM_HARMONICS > 1) ? $clog2(NUM_HARMONICS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HARMONICS - 1);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                           r_state;
  state_t                           w_state_next;
  logic [IDX_W-1:0]                 r_idx;
  logic [IDX_W-1:0]                 w_idx_inc;
  logic [NUM_HARMONICS*COEFF_W-1:0] r_work;
  logic [NUM_HARMONICS*COEFF_W-1:0] r_pend;
  logic                             r_pend_full;
  logic [WD_W-1:0]                  r_wd;
  logic [NUM_HARMONICS*MAG_W-1:0]   r_collect;
  logic [NUM_HARMONICS*MAG_W-1:0]   w_collect_next;
  logic [NUM_HARMONICS*MAG_W-1:0]   r_mags;
  logic [COEFF_W-1:0]               r_coeff;
  logic [COEFF_W-1:0]               w_coeff_next;
  logic [7:0]                       r_drop_cnt;
  logic                             r_timeout_err;
  logic                             r_busy;

  logic w_in_wait;
  logic w_wd_fire;
  logic w_slot_done;
  logic [MAG_W-1:0] w_slot_val;
  logic w_last;
  logic w_overrun;
  logic w_drop;
  logic w_promote;
  logic w_direct;
  logic w_pend_store;

  assign w_in_wait  = (r_state == S_WAIT);
  // done takes priority over the watchdog on its final cycle
  assign w_wd_fire  = w_in_wait && !mag_done_in && (r_wd == '0);
  assign w_slot_done = w_in_wait && (mag_done_in || (r_wd == '0));
  assign w_slot_val = mag_done_in ? mag_in : '0;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_idx_inc  = r_idx + IDX_W'(1);

  assign w_overrun  = frame_valid_in && (r_state != S_IDLE);
  assign w_drop     = w_overrun && r_pend_full;
  assign w_promote  = (r_state == S_DONE) && r_pend_full;
  // A frame arriving in DONE with the buffer empty is buffered and promoted in
  // the same step, so it goes straight into the work buffer.
  assign w_direct   = (r_state == S_DONE) && !r_pend_full && frame_valid_in;
  assign w_pend_store = w_overrun && !r_pend_full && (r_state != S_DONE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (frame_valid_in) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (w_slot_done) w_state_next = w_last ? S_DONE : S_ISSUE;
      S_DONE:  w_state_next = (r_pend_full || frame_valid_in) ? S_ISSUE : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_collect_next = r_collect;
    if (w_slot_done) begin
      w_collect_next[int'(r_idx)*MAG_W +: MAG_W] = w_slot_val;
    end
  end

  // The coefficient register is loaded on entry to ISSUE so the value is
  // already present in the start cycle and holds until the next issue.
  always_comb begin
    w_coeff_next = r_coeff;
    case (r_state)
      S_IDLE: begin
        if (frame_valid_in) w_coeff_next = frame_coeffs_in[COEFF_W-1:0];
      end
      S_WAIT: begin
        if (w_slot_done && !w_last) begin
          w_coeff_next = r_work[int'(w_idx_inc)*COEFF_W +: COEFF_W];
        end
      end
      S_DONE: begin
        if (r_pend_full)         w_coeff_next = r_pend[COEFF_W-1:0];
        else if (frame_valid_in) w_coeff_next = frame_coeffs_in[COEFF_W-1:0];
      end
      default: w_coeff_next = r_coeff;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_work        <= '0;
      r_pend        <= '0;
      r_pend_full   <= 1'b0;
      r_wd          <= '0;
      r_collect     <= '0;
      r_mags        <= '0;
      r_coeff       <= '0;
      r_drop_cnt    <= '0;
      r_timeout_err <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_busy    <= (w_state_next != S_IDLE);
      r_collect <= w_collect_next;
      r_coeff   <= w_coeff_next;

      // publish the whole vector at once, visible during the DONE cycle
      if (w_slot_done && w_last) r_mags <= w_collect_next;

      case (r_state)
        S_IDLE: begin
          if (frame_valid_in) begin
            r_work <= frame_coeffs_in;
            r_idx  <= '0;
          end
        end
        S_WAIT: begin
          if (w_slot_done && !w_last) r_idx <= w_idx_inc;
        end
        S_DONE: begin
          r_idx <= '0;
          if (w_promote)     r_work <= r_pend;
          else if (w_direct) r_work <= frame_coeffs_in;
        end
        default: ;
      endcase

      if (w_pend_store) begin
        r_pend      <= frame_coeffs_in;
        r_pend_full <= 1'b1;
      end else if (w_promote) begin
        r_pend_full <= 1'b0;
      end

      // watchdog down-counter, terminal count 0 means expiry
      if (r_state == S_ISSUE)          r_wd <= WD_LOAD;
      else if (w_in_wait && r_wd != '0) r_wd <= r_wd - WD_W'(1);

      if (w_wd_fire) r_timeout_err <= 1'b1;

      if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign mag_start_out     = (r_state == S_ISSUE);
  assign mag_coeff_out     = r_coeff;
  assign mag_clear_out     = w_wd_fire;
  assign mags_out          = r_mags;
  assign mags_valid_out    = (r_state == S_DONE);
  assign busy_out          = r_busy;
  assign frame_dropped_out = w_drop;
  assign drop_count_out    = r_drop_cnt;
  assign timeout_err_out   = r_timeout_err;

endmodule

// File: tb/tb_harmonic_mag_scheduler.sv
// Testbench for harmonic_mag_scheduler. The bench acts as the magnitude unit
// and keeps a frame-level reference model: each accepted frame gets a start
// cycle, per-harmonic latencies and an expected publish cycle, computed from
// arrival times with plain arithmetic.
module tb_harmonic_mag_scheduler;

  localparam int NH  = 5;
  localparam int CW  = 32;
  localparam int MW  = 32;
  localparam int TMO = 8;
  localparam int VW  = NH * MW;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             frame_valid_in;
  logic [NH*CW-1:0] frame_coeffs_in;
  logic             mag_start_out;
  logic [CW-1:0]    mag_coeff_out;
  logic             mag_done_in;
  logic [MW-1:0]    mag_in;
  logic             mag_clear_out;
  logic [VW-1:0]    mags_out;
  logic             mags_valid_out;
  logic             busy_out;
  logic             frame_dropped_out;
  logic [7:0]       drop_count_out;
  logic             timeout_err_out;

  harmonic_mag_scheduler #(
    .NUM_HARMONICS(NH), .COEFF_W(CW), .MAG_W(MW), .TIMEOUT(TMO)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .frame_valid_in(frame_valid_in), .frame_coeffs_in(frame_coeffs_in),
    .mag_start_out(mag_start_out), .mag_coeff_out(mag_coeff_out),
    .mag_done_in(mag_done_in), .mag_in(mag_in), .mag_clear_out(mag_clear_out),
    .mags_out(mags_out), .mags_valid_out(mags_valid_out), .busy_out(busy_out),
    .frame_dropped_out(frame_dropped_out), .drop_count_out(drop_count_out),
    .timeout_err_out(timeout_err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          cyc;
    logic [31:0] coeff;
    int          lat;
    bit          silent;
    logic [31:0] val;
  } start_t;

  typedef struct {
    int          s;
    int          v;
    logic [VW-1:0] mags;
  } frm_t;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  start_t      start_q[$];
  frm_t        frames_q[$];
  int          clear_q[$];
  int          last_v;
  logic [VW-1:0] last_mags;
  bit          err_model;
  int          drop_model;
  bit          exp_drop;
  int          cyc;

  // unit responder state
  int          done_cyc;
  logic [31:0] done_val;
  logic [31:0] cur_coeff;
  bit          real_done_now;

  // phase configuration
  int arr_q[$];
  int coeff_mode, val_mode, fixed_lat, silent_k, final_k, p_frame;
  bit silent_rand, spur_en;

  // phase observations
  int            cur_rel;
  int            n_valid, first_valid_rel, n_clear, first_drop_rel;
  logic [VW-1:0] first_mags;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    start_q.delete();
    frames_q.delete();
    clear_q.delete();
    last_v     = -1000;
    last_mags  = '0;
    err_model  = 0;
    drop_model = 0;
    done_cyc   = -1;
  endtask

  task automatic begin_phase();
    n_valid = 0; first_valid_rel = -1; n_clear = 0; first_drop_rel = -1;
    first_mags = '0;
  endtask

  task automatic model_arrival(input logic [NH*CW-1:0] co);
    frm_t   f;
    start_t st;
    int     t;
    if (frames_q.size() >= 2) begin
      exp_drop = 1;
    end else begin
      t = (cyc + 1 > last_v + 1) ? cyc + 1 : last_v + 1;
      f.s = t;
      f.mags = '0;
      for (int k = 0; k < NH; k++) begin
        st.cyc    = t;
        st.coeff  = co[k*CW +: CW];
        st.lat    = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(TMO, 1));
        if (k == final_k) st.lat = TMO;
        st.silent = (k == silent_k) || (silent_rand && $urandom_range(9) == 0);
        st.val    = (val_mode == 0) ? 32'(10 * (k + 1)) : $urandom;
        start_q.push_back(st);
        if (st.silent) begin
          clear_q.push_back(t + TMO);
          t += TMO + 1;
        end else begin
          f.mags[k*MW +: MW] = st.val;
          t += st.lat + 1;
        end
      end
      f.v = t;
      frames_q.push_back(f);
      last_v = t;
    end
  endtask

  task automatic check_cycle();
    bit exp_start, exp_valid, exp_clear, exp_busy;
    exp_start = (start_q.size() > 0) && (start_q[0].cyc == cyc);
    chk("mag_start", VW'(mag_start_out), VW'(exp_start));
    if (exp_start) begin
      chk("mag_coeff", VW'(mag_coeff_out), VW'(start_q[0].coeff));
      cur_coeff = start_q[0].coeff;
      if (!start_q[0].silent) begin
        done_cyc = cyc + start_q[0].lat;
        done_val = start_q[0].val;
      end
      void'(start_q.pop_front());
    end
    if (real_done_now) chk("coeff_hold", VW'(mag_coeff_out), VW'(cur_coeff));

    exp_valid = (frames_q.size() > 0) && (frames_q[0].v == cyc);
    chk("mags_valid", VW'(mags_valid_out), VW'(exp_valid));
    if (exp_valid) last_mags = frames_q[0].mags;
    chk("mags_out", mags_out, last_mags);

    exp_clear = (clear_q.size() > 0) && (clear_q[0] == cyc);
    if (exp_clear) void'(clear_q.pop_front());
    chk("mag_clear", VW'(mag_clear_out), VW'(exp_clear));
    chk("timeout_err", VW'(timeout_err_out), VW'(err_model));
    if (exp_clear) err_model = 1;

    exp_busy = (frames_q.size() > 0) && (frames_q[0].s <= cyc);
    chk("busy", VW'(busy_out), VW'(exp_busy));

    chk("frame_dropped", VW'(frame_dropped_out), VW'(exp_drop));
    chk("drop_count", VW'(drop_count_out), VW'(drop_model));
    if (exp_drop && drop_model < 255) drop_model++;

    if (mags_valid_out) begin
      if (first_valid_rel < 0) begin
        first_valid_rel = cur_rel;
        first_mags = mags_out;
      end
      n_valid++;
    end
    if (mag_clear_out) n_clear++;
    if (frame_dropped_out && first_drop_rel < 0) first_drop_rel = cur_rel;
  endtask

  task automatic run(input int ncyc, input int rst_at);
    logic [NH*CW-1:0] co;
    bit fv;
    begin_phase();
    for (int rel = 0; rel < ncyc; rel++) begin
      cur_rel = rel;
      while (frames_q.size() > 0 && frames_q[0].v < cyc) void'(frames_q.pop_front());
      exp_drop = 0;
      real_done_now = 0;
      if (rel == rst_at) begin
        rst_in = 1; frame_valid_in = 0; mag_done_in = 0;
      end else begin
        rst_in = 0;
        fv = ($urandom_range(99) < p_frame);
        foreach (arr_q[i]) if (arr_q[i] == rel) fv = 1;
        for (int k = 0; k < NH; k++)
          co[k*CW +: CW] = (coeff_mode == 0) ? 32'(k + 1) : $urandom;
        frame_valid_in  = fv;
        frame_coeffs_in = co;
        if (done_cyc == cyc) begin
          mag_done_in = 1; mag_in = done_val; done_cyc = -1; real_done_now = 1;
        end else if (spur_en && ((start_q.size() > 0 && start_q[0].cyc == cyc) ||
                                 frames_q.size() == 0) && $urandom_range(1) == 0) begin
          mag_done_in = 1; mag_in = $urandom;
        end else begin
          mag_done_in = 0; mag_in = $urandom;
        end
        if (fv) model_arrival(co);
      end
      @(negedge clk_in);
      if (rel != rst_at) check_cycle();
      @(posedge clk_in);
      #1;
      if (rel == rst_at) model_reset();
      cyc++;
    end
    frame_valid_in = 0;
    mag_done_in = 0;
    rst_in = 0;
  endtask

  task automatic cfg(input int cm, input int vm, input int fl, input int sk,
                     input int fk, input bit sr, input bit sp, input int pf);
    coeff_mode = cm; val_mode = vm; fixed_lat = fl; silent_k = sk;
    final_k = fk; silent_rand = sr; spur_en = sp; p_frame = pf;
  endtask

  initial begin
    logic [VW-1:0] p1_exp;
    rst_in = 1; frame_valid_in = 0; frame_coeffs_in = '0;
    mag_done_in = 0; mag_in = '0;
    cyc = 0; cur_rel = 0; cur_coeff = '0; real_done_now = 0; exp_drop = 0;
    model_reset();
    begin_phase();

    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_start", VW'(mag_start_out), '0);
    chk("rst_coeff", VW'(mag_coeff_out), '0);
    chk("rst_clear", VW'(mag_clear_out), '0);
    chk("rst_mags", mags_out, '0);
    chk("rst_valid", VW'(mags_valid_out), '0);
    chk("rst_busy", VW'(busy_out), '0);
    chk("rst_dropped", VW'(frame_dropped_out), '0);
    chk("rst_drop_cnt", VW'(drop_count_out), '0);
    chk("rst_tmo_err", VW'(timeout_err_out), '0);
    @(posedge clk_in);
    #1;
    rst_in = 0;

    // single frame, L=3, results 10*(k+1)
    cfg(0, 0, 3, -1, -1, 0, 0, 0);
    arr_q = '{0};
    run(30, -1);
    p1_exp = {32'd50, 32'd40, 32'd30, 32'd20, 32'd10};
    chk("p1_valid_cycle", VW'(first_valid_rel), VW'(21));
    chk("p1_valid_count", VW'(n_valid), VW'(1));
    chk("p1_mags", first_mags, p1_exp);

    // back-to-back: second frame held in pending
    arr_q = '{0, 6};
    run(50, -1);
    chk("p2_valid_count", VW'(n_valid), VW'(2));
    chk("p2_no_drop", VW'(drop_count_out), '0);

    // overrun: third frame dropped
    arr_q = '{0, 3, 7};
    run(50, -1);
    chk("p3_drop_cycle", VW'(first_drop_rel), VW'(7));
    chk("p3_drop_count", VW'(drop_count_out), VW'(1));
    chk("p3_valid_count", VW'(n_valid), VW'(2));

    // spurious dones in IDLE/ISSUE, done on the watchdog's final cycle
    cfg(1, 1, 3, -1, 1, 0, 1, 0);
    arr_q = '{2};
    run(60, -1);
    chk("p5_tmo_err", VW'(timeout_err_out), '0);
    chk("p5_no_clear", VW'(n_clear), '0);

    // watchdog: unit silent for harmonic 2
    cfg(0, 0, 3, 2, -1, 0, 0, 0);
    arr_q = '{0};
    run(50, -1);
    chk("p4_clear_count", VW'(n_clear), VW'(1));
    chk("p4_slot2", VW'(mags_out[2*MW +: MW]), '0);
    chk("p4_slot3", VW'(mags_out[3*MW +: MW]), VW'(40));
    chk("p4_tmo_err", VW'(timeout_err_out), VW'(1));

    // reset mid-frame with pending full, then a fresh frame
    cfg(1, 1, 3, -1, -1, 0, 0, 0);
    arr_q = '{0, 3, 20};
    run(70, 10);
    chk("p6_valid_count", VW'(n_valid), VW'(1));
    chk("p6_valid_cycle", VW'(first_valid_rel), VW'(41));

    // randomized traffic, latencies and silent harmonics
    cfg(1, 1, 0, -1, -1, 1, 1, 4);
    arr_q.delete();
    run(1500, -1);

    // flood to saturate the drop counter
    cfg(1, 1, 1, -1, -1, 0, 0, 100);
    run(400, -1);
    cfg(1, 1, 1, -1, -1, 0, 0, 0);
    run(30, -1);
    chk("flood_drop_sat", VW'(drop_count_out), VW'(255));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
